// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// PC command encoding used by the control block.
package cpu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    PC_NOP  = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;

endpackage

// File: rtl/return_stack.sv
// Parametrised LIFO holding return addresses.
// Push on full and pop on empty are ignored here.
module return_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_m1  = sp - SP_W'(1);
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_m1[IDX_W-1:0];
  assign top    = empty ? '0 : mem[rd_idx];

  // Occupancy count; push wins if both are raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // Entry storage; slots above sp are never read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with return-address stack.
// Decodes one PC command per cycle and drives the bus.
module pc_call_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [OP_W-1:0]       op,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  out_en,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  output logic [SP_W-1:0]       sp,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC =
    ADDR_WIDTH'(RESET_ADDR);

  pc_op_t                cmd;
  logic                  push;
  logic                  pop;
  logic                  ovf_set;
  logic                  unf_set;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] top;

  assign cmd    = pc_op_t'(op);
  assign pc_inc = pc + ADDR_WIDTH'(1);

  return_stack #(
    .W     (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Command decode; faulting CALL/RET leave pc alone.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    pc_nxt  = pc;
    if (en) begin
      case (cmd)
        PC_INC:  pc_nxt = pc_inc;
        PC_LOAD: pc_nxt = addr_in;
        PC_CALL: begin
          if (stack_full) begin
            ovf_set = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = addr_in;
          end
        end
        PC_RET: begin
          if (stack_empty) begin
            unf_set = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = top;
          end
        end
        default: pc_nxt = pc;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RST_PC;
    else     pc <= pc_nxt;
  end

  // Sticky faults; a new fault beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  assign bus_oe  = out_en;
  assign bus_out = out_en ? pc : '0;

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program-counter unit for the 8-bit CPU, successor to the fixed 4-bit counter. Adds configurable address width, a hardware return-address stack (CALL/RET), a reset vector, and sticky stack-fault flags. Sits between the control block, which issues one encoded PC command per cycle, and the shared data bus, which it drives on request and loads jump targets from.

## Interface
Parameters:
- ADDR_WIDTH, 4, width of PC, jump target and stack entries (≥2)
- STACK_DEPTH, 4, number of return-address entries (≥1)
- RESET_ADDR, 0, PC value after reset

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  command qualifier; when 0 the command is ignored (NOP)
- op  input  3  PC command, encoding from package
- addr_in  input  ADDR_WIDTH  jump/call target from bus
- out_en  input  1  drive PC onto bus
- clr_err  input  1  clears sticky fault flags
- pc  output  ADDR_WIDTH  current program counter
- bus_out  output  ADDR_WIDTH  pc when out_en, else 0
- bus_oe  output  1  equals out_en
- sp  output  clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_full  output  1  sp == STACK_DEPTH
- stack_empty  output  1  sp == 0
- overflow  output  1  sticky: CALL attempted while full
- underflow  output  1  sticky: RET attempted while empty

## Operation
- Commands (ignored when en=0): NOP hold; INC pc←pc+1; LOAD pc←addr_in; CALL push pc+1, pc←addr_in; RET pc←top, pop.
- All PC arithmetic modulo 2^ADDR_WIDTH; INC at all-ones wraps to 0; CALL at all-ones pushes 0.
- CALL when full: no push, pc unchanged, overflow←1.
- RET when empty: no pop, pc unchanged, underflow←1.
- Undefined op codes behave as NOP.
- clr_err clears both flags; a fault in the same cycle as clr_err wins (flag set).
- Stack is LIFO; entries above sp are don't-care and never observable.
- bus_out/bus_oe combinational from pc and out_en; never X after reset.
- Reset (async assert, any time incl. mid-CALL): pc=RESET_ADDR, sp=0, overflow=underflow=0; bus_out follows out_en.

## Timing
- Command sampled at rising edge; new pc, sp, flags visible immediately after that edge (1-cycle latency).
- Back-to-back CALL/RET every cycle supported, no bubbles; RET directly after CALL returns to CALL address+1.
- stack_full/stack_empty combinational from sp, valid same cycle as sp.
- Reset deassertion is synchronised externally; first command honoured on first edge after rst low.

## Structure
- Shared package cpu_pkg: pc_op_t enum (NOP=0, INC=1, LOAD=2, CALL=3, RET=4), op width constant.
- Sub-module return_stack: parametrised LIFO (push, pop, din, top, sp, full, empty); pc_call_stack holds pc register, command decode, fault flags, bus drive.

## Test plan
- Reset with ADDR_WIDTH=4, RESET_ADDR=3 -> pc=3, sp=0, stack_empty=1, flags 0; out_en=1 -> bus_out=3, bus_oe=1.
- 16 INCs from pc=0 -> pc returns to 0; en=0 with INC -> pc unchanged.
- pc=5, CALL addr_in=0xA -> pc=0xA, sp=1; RET -> pc=6, sp=0.
- DEPTH=4: five nested CALLs -> sp=4, stack_full=1, fifth CALL leaves pc unchanged, overflow=1; four RETs unwind in reverse order; clr_err -> overflow=0.
- RET on empty -> pc unchanged, underflow=1; RET with clr_err same cycle -> underflow stays 1.
- rst asserted between edges during CALL sequence (sp=2) -> immediately pc=RESET_ADDR, sp=0, flags 0.
